// File: rtl/seg7_scan_drv.sv
// Eight-digit multiplexed 7-segment driver with per-frame snapshot, decimal points and blink.
// Outputs decode registered state only; inputs take effect at the next frame boundary (EN after one edge).
module seg7_scan_drv #(
  parameter int DIG_CYCLES   = 50000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic [31:0] Disp_num,
  input  logic [7:0]  point_in,
  input  logic [7:0]  blink_in,
  output logic [7:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        frame_start
);

  localparam int CW = (DIG_CYCLES > 1) ? $clog2(DIG_CYCLES) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIG_CYCLES - 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    dig;
  logic          valid;
  logic [31:0]   snap_num;
  logic [7:0]    snap_pt;
  logic [7:0]    snap_bl;
  logic [FW-1:0] fcnt;
  logic          ph;
  logic          en_q;

  logic          dig_last;
  logic          boundary;

  assign dig_last = (cnt == CNT_LAST);
  assign boundary = dig_last && (dig == 3'd7);

  // Reset parks the scan on the last cycle of digit 7 so the first free edge is a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= CNT_LAST;
      dig      <= 3'd7;
      valid    <= 1'b0;
      snap_num <= '0;
      snap_pt  <= '0;
      snap_bl  <= '0;
      fcnt     <= '0;
      ph       <= 1'b1;
      en_q     <= 1'b0;
    end else begin
      en_q <= EN;
      if (dig_last) begin
        cnt <= '0;
        dig <= dig + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (boundary) begin
        snap_num <= Disp_num;
        snap_pt  <= point_in;
        snap_bl  <= blink_in;
        valid    <= 1'b1;
        if (valid) begin
          if (fcnt == FCNT_LAST) begin
            fcnt <= '0;
            ph   <= ~ph;
          end else begin
            fcnt <= fcnt + FW'(1);
          end
        end
      end
    end
  end

  logic [3:0] nib;
  logic [6:0] seg_hex;
  logic       blanked;

  assign nib     = snap_num[{dig, 2'b00} +: 4];
  assign blanked = snap_bl[dig] && !ph;

  always_comb begin
    seg_hex = 7'h7F;
    case (nib)
      4'h0: seg_hex = 7'h40;
      4'h1: seg_hex = 7'h79;
      4'h2: seg_hex = 7'h24;
      4'h3: seg_hex = 7'h30;
      4'h4: seg_hex = 7'h19;
      4'h5: seg_hex = 7'h12;
      4'h6: seg_hex = 7'h02;
      4'h7: seg_hex = 7'h78;
      4'h8: seg_hex = 7'h00;
      4'h9: seg_hex = 7'h10;
      4'hA: seg_hex = 7'h08;
      4'hB: seg_hex = 7'h03;
      4'hC: seg_hex = 7'h46;
      4'hD: seg_hex = 7'h21;
      4'hE: seg_hex = 7'h06;
      4'hF: seg_hex = 7'h0E;
      default: seg_hex = 7'h7F;
    endcase
  end

  always_comb begin
    AN      = 8'hFF;
    SEGMENT = 8'hFF;
    if (valid && en_q) begin
      AN = ~(8'h01 << dig);
      if (!blanked) begin
        SEGMENT = {~snap_pt[dig], seg_hex};
      end
    end
  end

  assign frame_start = valid && (dig == 3'd0) && (cnt == '0);

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Directed bench for seg7_scan_drv with DIG_CYCLES=4, BLINK_FRAMES=2; cycle 1 is the first edge after reset release.
module tb_seg7_scan_drv;

  localparam int DC = 4;
  localparam int BF = 2;
  localparam int FRAME = 8 * DC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [31:0] disp = 32'h0;
  logic [7:0]  pt = 8'h0;
  logic [7:0]  bl = 8'h0;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        fs;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg7_scan_drv #(.DIG_CYCLES(DC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .EN(en), .Disp_num(disp), .point_in(pt), .blink_in(bl),
    .AN(an), .SEGMENT(seg), .frame_start(fs)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_an"}, an, 8'hFF);
    chk({tag, "_seg"}, seg, 8'hFF);
    chk({tag, "_fs"}, {7'b0, fs}, 8'h00);
  endtask

  // Expected outputs for the current cycle given the frame's captured data.
  task automatic chk_cyc(input string tag, input logic [31:0] fd, input logic [7:0] fp,
                         input logic [7:0] fb, input bit vis, input bit on);
    int d;
    logic [7:0] e_an, e_seg, e_tab;
    logic e_fs;
    d     = ((cyc - 1) / DC) % 8;
    e_fs  = ((cyc - 1) % FRAME) == 0;
    e_an  = 8'hFF;
    e_seg = 8'hFF;
    e_tab = hex_tab[fd[4*d +: 4]];
    if (on) begin
      e_an = ~(8'h01 << d);
      if (!(fb[d] && !vis)) e_seg = {~fp[d], e_tab[6:0]};
    end
    chk({tag, "_an"}, an, e_an);
    chk({tag, "_seg"}, seg, e_seg);
    chk({tag, "_fs"}, {7'b0, fs}, {7'b0, e_fs});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk_blank("rst_hold");
    tick();
    chk_blank("rst_hold2");
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // Scan order and tear-free snapshot: new value lands mid-frame 1, shows from frame 2.
    disp = 32'h7654_3210; pt = 8'h00; bl = 8'h00; en = 1'b1;
    do_reset();
    for (int i = 0; i < 65; i++) begin
      if (cyc == 9) disp = 32'hFFFF_FFFF;
      tick();
      chk_cyc("scan", (cyc <= FRAME) ? 32'h7654_3210 : 32'hFFFF_FFFF, 8'h00, 8'h00, 1'b1, 1'b1);
    end

    // Decimal point on digit 0 only.
    disp = 32'h7654_3210; pt = 8'h01;
    do_reset();
    tick();
    chk("pt_c1_seg", seg, 8'h40);
    chk("pt_c1_an", an, 8'hFE);
    for (int i = 1; i < FRAME; i++) begin
      tick();
      chk_cyc("point", 32'h7654_3210, 8'h01, 8'h00, 1'b1, 1'b1);
    end

    // Blink digit 1: visible frames 1-2, blank 3-4, visible 5.
    pt = 8'h00; bl = 8'h02;
    do_reset();
    for (int i = 0; i < 5 * FRAME; i++) begin
      int fr;
      tick();
      fr = (cyc - 1) / FRAME + 1;
      chk_cyc("blink", 32'h7654_3210, 8'h00, 8'h02, !(fr == 3 || fr == 4), 1'b1);
    end

    // Enable held low, then raised so the scan is picked up mid-frame without restarting.
    bl = 8'h00; en = 1'b0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (cyc == 9) en = 1'b1;
      tick();
      chk_cyc("enable", 32'h7654_3210, 8'h00, 8'h00, 1'b1, cyc >= 10);
    end

    // Mid-frame reset while blink phase is low: frame abandoned, phase restored.
    bl = 8'h02; en = 1'b1;
    do_reset();
    for (int i = 0; i < 70; i++) begin
      tick();
      chk_cyc("pre_mid", 32'h7654_3210, 8'h00, 8'h02, cyc <= 2 * FRAME, 1'b1);
    end
    rst = 1'b1;
    tick();
    chk_blank("mid_rst");
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < FRAME + 1; i++) begin
      tick();
      chk_cyc("restart", 32'h7654_3210, 8'h00, 8'h02, 1'b1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
